// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO between the echo/control FSM and the UART transmitter.
// Queues single-cycle write strobes and drains them one frame at a time via tx_start/tx_done.
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_50M,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  clr_overflow,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_start,
    input  logic                  tx_done,
    output logic                  busy,
    output logic [2:0]            state_dbg
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    // Handshake: a byte is popped only from IDLE; tx_start pulses for one cycle
    // and the byte stays on tx_data until the transmitter returns a tx_done pulse.
    typedef enum logic [2:0] {
        IDLE      = 3'b001,
        START     = 3'b010,
        WAIT_DONE = 3'b100
    } state_t;

    state_t                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]   wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    full_q, full_d;
    logic                    empty_q, empty_d;
    logic                    overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                    tx_start_q, tx_start_d;
    logic                    busy_q, busy_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic                    wr_ok;
    logic                    pop;

    assign wr_ok = wr_en && !full_q;

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        tx_data_d  = tx_data_q;
        tx_start_d = tx_start_q;
        overflow_d = overflow_q;
        pop        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!empty_q) begin
                    pop       = 1'b1;
                    tx_data_d = mem_q[rptr_q];
                    rptr_d    = rptr_q + DEPTH_LOG2'(1);
                    state_d   = START;
                end
            end
            START: begin
                tx_start_d = 1'b1;
                state_d    = WAIT_DONE;
            end
            WAIT_DONE: begin
                tx_start_d = 1'b0;
                if (tx_done) state_d = IDLE;
            end
            default: begin
                tx_start_d = 1'b0;
                state_d    = IDLE;
            end
        endcase

        if (wr_ok) wptr_d = wptr_q + DEPTH_LOG2'(1);

        count_d = count_q + CW'(wr_ok) - CW'(pop);
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);

        // A dropped write takes priority over a same-cycle clear.
        if (wr_en && full_q)   overflow_d = 1'b1;
        else if (clr_overflow) overflow_d = 1'b0;

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_50M or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
        end
    end

    // Storage needs no reset: empty/count gate every read.
    always_ff @(posedge clk_50M) begin
        if (wr_ok) mem_q[wptr_q] <= wr_data;
    end

    assign full      = full_q;
    assign empty     = empty_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign tx_data   = tx_data_q;
    assign tx_start  = tx_start_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;

endmodule
